pdc_update_ctrl: RTL and testbench

Sequencing controller for the 2-bit branch-history counter table (PDC) used by the branch predictor. The table itself has no reset loop. This block owns the table's single write port: it sweeps every entry to weakly-not-taken after reset or on a clear request, then buffers ROB branch-commit outcomes in a small queue and applies one saturating counter update per cycle. It sits between the ReorderBuffer commit path and the predictor table.

---
 rtl/pdc_update_ctrl_pkg.sv | 42 ++++
 rtl/pdc_update_ctrl_fifo.sv | 83 ++++++++
 rtl/pdc_update_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pdc_update_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdc_update_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pdc_update_ctrl_pkg
//
// Shared definitions for the branch-history counter table (PDC) update
// controller: 2-bit counter encodings, the value every entry is initialised
// to, the controller state type, the default table index width and the
// saturating counter step used when a branch outcome is applied.
// ---------------------------------------------------------------------------
package pdc_update_ctrl_pkg;

    // Default table index width (table has 2^PDC_IDX_W entries).
    localparam int PDC_IDX_W = 8;

    // 2-bit counter encodings.
    localparam logic [1:0] CNT_SNT  = 2'b00;
    localparam logic [1:0] CNT_WNT  = 2'b01;
    localparam logic [1:0] CNT_WT   = 2'b10;
    localparam logic [1:0] CNT_ST   = 2'b11;

    // Every entry is swept to weakly-not-taken after reset or a clear.
    localparam logic [1:0] CNT_INIT = CNT_WNT;

    // Controller states: sweeping the table, or applying commit outcomes.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pdc_state_t;

    // One saturating step of a 2-bit counter toward taken or not-taken.
    function automatic logic [1:0] satUpdate(input logic [1:0] cur, input logic taken);
        logic [1:0] res;
        res = cur;
        case (cur)
            CNT_SNT: res = taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: res = taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  res = taken ? CNT_ST  : CNT_WNT;
            default: res = taken ? CNT_ST  : CNT_WT;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pdc_update_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// pdc_upd_fifo
//
// Small synchronous FIFO that buffers committed branch outcomes until the
// update controller can apply them to the counter table.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_flush      drop all contents (wins over a same-cycle push/pop)
//   i_push       write i_wdata (ignored when full)
//   i_wdata      entry to store
//   i_pop        discard the head entry (ignored when empty)
//   o_rdata      current head entry (combinational)
//   o_empty      no entries stored
//   o_full       DEPTH entries stored
// ---------------------------------------------------------------------------
module pdc_upd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == FULL_CNT);
    assign o_rdata  = r_mem[r_rdPtr];

    // A flush cancels any push or pop requested in the same cycle.
    assign w_doPush = i_push & ~o_full  & ~i_flush;
    assign w_doPop  = i_pop  & ~o_empty & ~i_flush;

    // Storage is reset so the head (and thus the table read index) is
    // a known zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= r_count + (PTR_W+1)'(w_doPush) - (PTR_W+1)'(w_doPop);
        end
    end

endmodule

// File: rtl/pdc_update_ctrl.sv
// ---------------------------------------------------------------------------
// pdc_update_ctrl
//
// Owns the single write port of the 2-bit branch-history counter table.
// After reset or a clear request it sweeps every entry to weakly-not-taken,
// then applies queued branch-commit outcomes from the ROB, one saturating
// counter update per cycle, through a registered write stage.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   i_rdy                global enable; low freezes all state
//   i_clear_req          pulse: re-initialise the whole table
//   i_ROB_input_valid    commit outcome valid
//   i_ROB_hit            branch taken (1) / not taken (0)
//   i_ROB_pc             committed branch PC
//   o_ROB_ready          outcome queue can accept this cycle
//   o_PDC_rd_idx         table read index (head of queue)
//   i_PDC_rd_cnt         table read data for o_PDC_rd_idx
//   o_PDC_wr_en          table write enable
//   o_PDC_wr_idx         table write index
//   o_PDC_wr_cnt         table write data
//   o_IF_pred_ready      table contents valid for prediction
// ---------------------------------------------------------------------------
module pdc_update_ctrl
    import pdc_update_ctrl_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int IDX_W  = PDC_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rdy,
    input  logic             i_clear_req,
    input  logic             i_ROB_input_valid,
    input  logic             i_ROB_hit,
    input  logic [31:0]      i_ROB_pc,
    output logic             o_ROB_ready,
    output logic [IDX_W-1:0] o_PDC_rd_idx,
    input  logic [1:0]       i_PDC_rd_cnt,
    output logic             o_PDC_wr_en,
    output logic [IDX_W-1:0] o_PDC_wr_idx,
    output logic [1:0]       o_PDC_wr_cnt,
    output logic             o_IF_pred_ready
);

    pdc_state_t       r_state;
    pdc_state_t       w_nextState;

    logic [IDX_W-1:0] r_sweepIdx;

    // Write stage: what the table will be written with at the next rdy edge.
    logic             r_stgValid;
    logic             r_stgInit;
    logic [IDX_W-1:0] r_stgIdx;
    logic [1:0]       r_stgCnt;

    logic             w_fifoEmpty;
    logic             w_fifoFull;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic [IDX_W:0]   w_fifoWdata;
    logic [IDX_W:0]   w_head;
    logic [IDX_W-1:0] w_headIdx;
    logic             w_headHit;
    logic [1:0]       w_curCnt;
    logic [1:0]       w_nextCnt;
    logic             w_sweepLast;
    logic             w_unusedPcBits;

    // Only the word-aligned index bits of the PC select a table entry.
    assign w_fifoWdata    = {i_ROB_pc[IDX_W+1:2], i_ROB_hit};
    assign w_unusedPcBits = ^{i_ROB_pc[31:IDX_W+2], i_ROB_pc[1:0]};

    // A clear drops any outcome offered in the same cycle.
    assign w_flush = i_rdy & i_clear_req;
    assign w_push  = i_rdy & ~i_clear_req & i_ROB_input_valid & ~w_fifoFull;
    assign w_pop   = i_rdy & ~i_clear_req & (r_state == ST_RUN) & ~w_fifoEmpty;

    pdc_upd_fifo #(
        .WIDTH (IDX_W + 1),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_wdata (w_fifoWdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_fifoEmpty),
        .o_full  (w_fifoFull)
    );

    assign w_headIdx = w_head[IDX_W:1];
    assign w_headHit = w_head[0];

    // The table only reflects the staged write after the next edge, so a
    // back-to-back update to the same entry must take the staged value.
    assign w_curCnt    = (r_stgValid && (r_stgIdx == w_headIdx)) ? r_stgCnt : i_PDC_rd_cnt;
    assign w_nextCnt   = satUpdate(w_curCnt, w_headHit);
    assign w_sweepLast = &r_sweepIdx;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a clear always restarts the sweep; the sweep ends once
    // the last index has been loaded into the write stage.
    always_comb begin
        w_nextState = r_state;
        if (i_rdy) begin
            if (i_clear_req) begin
                w_nextState = ST_INIT;
            end else if ((r_state == ST_INIT) && w_sweepLast) begin
                w_nextState = ST_RUN;
            end
        end
    end

    // Sweep counter and write stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sweepIdx <= '0;
            r_stgValid <= 1'b0;
            r_stgInit  <= 1'b0;
            r_stgIdx   <= '0;
            r_stgCnt   <= CNT_INIT;
        end else if (i_rdy) begin
            if (i_clear_req) begin
                r_stgValid <= 1'b0;
                r_sweepIdx <= '0;
            end else if (r_state == ST_INIT) begin
                r_stgValid <= 1'b1;
                r_stgInit  <= 1'b1;
                r_stgIdx   <= r_sweepIdx;
                r_stgCnt   <= CNT_INIT;
                r_sweepIdx <= r_sweepIdx + 1'b1;
            end else if (w_pop) begin
                r_stgValid <= 1'b1;
                r_stgInit  <= 1'b0;
                r_stgIdx   <= w_headIdx;
                r_stgCnt   <= w_nextCnt;
            end else begin
                r_stgValid <= 1'b0;
            end
        end
    end

    assign o_ROB_ready     = i_rdy & ~w_fifoFull;
    assign o_PDC_rd_idx    = w_headIdx;
    assign o_PDC_wr_en     = r_stgValid & i_rdy;
    assign o_PDC_wr_idx    = r_stgIdx;
    assign o_PDC_wr_cnt    = r_stgCnt;
    assign o_IF_pred_ready = (r_state == ST_RUN) & ~(r_stgValid & r_stgInit);

endmodule

// File: tb/tb_pdc_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pdc_update_ctrl
//
// Bench for the PDC update controller. A behavioural table model turns each
// accepted commit into the counter value the table must end up with, kept as
// an ordered list of expected writes; every observed table write is matched
// against that list. The table itself is modelled as a plain array written
// from the controller's write port and read combinationally.
// ---------------------------------------------------------------------------
module tb_pdc_update_ctrl;

    localparam int IDX_W   = 8;
    localparam int QDEPTH  = 4;
    localparam int ENTRIES = 1 << IDX_W;

    typedef struct {
        int idx;
        int cnt;
        int cyc;
    } expWr_t;

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic             rdy       = 1'b0;
    logic             clearReq  = 1'b0;
    logic             robValid  = 1'b0;
    logic             robHit    = 1'b0;
    logic [31:0]      robPc     = '0;
    logic             robReady;
    logic [IDX_W-1:0] rdIdx;
    logic [1:0]       rdCnt;
    logic             wrEn;
    logic [IDX_W-1:0] wrIdx;
    logic [1:0]       wrCnt;
    logic             predReady;

    logic [1:0]       envTable [ENTRIES];
    int               modelTable [ENTRIES];
    expWr_t           expWrites [$];
    int               testsRun    = 0;
    int               testsFailed = 0;
    int               cycleCnt    = 0;

    pdc_update_ctrl #(
        .QDEPTH (QDEPTH),
        .IDX_W  (IDX_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_rdy             (rdy),
        .i_clear_req       (clearReq),
        .i_ROB_input_valid (robValid),
        .i_ROB_hit         (robHit),
        .i_ROB_pc          (robPc),
        .o_ROB_ready       (robReady),
        .o_PDC_rd_idx      (rdIdx),
        .i_PDC_rd_cnt      (rdCnt),
        .o_PDC_wr_en       (wrEn),
        .o_PDC_wr_idx      (wrIdx),
        .o_PDC_wr_cnt      (wrCnt),
        .o_IF_pred_ready   (predReady)
    );

    // Free-running clock and a cycle counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
    end

    // The counter table the controller drives: written at posedge, read
    // combinationally.
    always @(posedge clk) begin
        if (wrEn === 1'b1) begin
            envTable[wrIdx] <= wrCnt;
        end
    end

    assign rdCnt = envTable[rdIdx];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycleCnt);
        end
    endtask

    // Every observed write must be the next expected one.
    always @(negedge clk) begin
        if (!rst && wrEn === 1'b1) begin
            if (expWrites.size() == 0) begin
                checkOutput("spuriousWrEn", wrEn, 1'b0);
            end else begin
                expWr_t e;
                e = expWrites.pop_front();
                checkOutput("wrIdx", wrIdx, e.idx);
                checkOutput("wrCnt", wrCnt, e.cnt);
                if (e.cyc >= 0) begin
                    checkOutput("wrCycle", cycleCnt, e.cyc);
                end
            end
        end
    end

    // Whole-table sweep: every entry becomes weakly-not-taken, in index order.
    task automatic modelInitSweep(input int firstCycle);
        for (int i = 0; i < ENTRIES; i++) begin
            expWr_t e;
            e.idx = i;
            e.cnt = 1;
            e.cyc = (firstCycle < 0) ? -1 : firstCycle + i;
            modelTable[i] = 1;
            expWrites.push_back(e);
        end
    endtask

    // One committed outcome: saturating step of the addressed counter.
    task automatic modelCommit(input int idx, input logic hit, input int cyc);
        expWr_t e;
        int     cur;
        cur = modelTable[idx];
        if (hit) begin
            cur = (cur + 1 > 3) ? 3 : cur + 1;
        end else begin
            cur = (cur - 1 < 0) ? 0 : cur - 1;
        end
        modelTable[idx] = cur;
        e.idx = idx;
        e.cnt = cur;
        e.cyc = cyc;
        expWrites.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one outcome until accepted (bounded). expReady >= 0 checks
    // the ready seen on the first offered cycle.
    task automatic applyStimulus(input logic [31:0] pc, input logic hit, input int expReady, input bit timed);
        int waitCnt;
        bit done;
        robValid = 1'b1;
        robPc    = pc;
        robHit   = hit;
        waitCnt  = 0;
        done     = 0;
        while (!done) begin
            @(negedge clk);
            if (waitCnt == 0 && expReady >= 0) begin
                checkOutput("robReady", robReady, expReady);
            end
            if (robReady === 1'b1) begin
                modelCommit(int'(pc[IDX_W+1:2]), hit, timed ? cycleCnt + 2 : -1);
                done = 1;
            end else if (waitCnt >= 500) begin
                checkOutput("acceptTimeout", robReady, 1'b1);
                done = 1;
            end
            waitCnt++;
            tick();
        end
        robValid = 1'b0;
    endtask

    task automatic doClear(input bit timed);
        clearReq = 1'b1;
        tick();
        clearReq = 1'b0;
        expWrites.delete();
        modelInitSweep(timed ? cycleCnt + 1 : -1);
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (expWrites.size() != 0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput(tag, expWrites.size(), 0);
    endtask

    task automatic rdyLow(input string tag);
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput({tag, "WrEn"}, wrEn, 1'b0);
            checkOutput({tag, "RobReady"}, robReady, 1'b0);
        end
        tick();
        rdy = 1'b1;
    endtask

    initial begin
        // Reset values, with rdy low during reset.
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstWrEn", wrEn, 1'b0);
        checkOutput("rstWrIdx", wrIdx, 0);
        checkOutput("rstWrCnt", wrCnt, 2'b01);
        checkOutput("rstPredReady", predReady, 1'b0);
        checkOutput("rstRdIdx", rdIdx, 0);
        checkOutput("rstRobReady", robReady, 1'b0);
        rdy = 1'b1;
        tick();
        rst = 1'b0;
        modelInitSweep(cycleCnt + 1);

        // Initial sweep: writes on cycles 1..256, prediction ready from 257.
        for (int n = 1; n <= 258; n++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("predReadySweep", predReady, (n >= 257));
            if (n == 1) begin
                checkOutput("firstWrEn", wrEn, 1'b1);
            end
            if (n == 257) begin
                checkOutput("wrEnAfterSweep", wrEn, 1'b0);
            end
        end
        checkOutput("sweepWrites", expWrites.size(), 0);
        tick();

        // Back-to-back taken updates to one entry (stage bypass).
        applyStimulus(32'h0000_0040, 1'b1, 1, 1);
        applyStimulus(32'h0000_0040, 1'b1, 1, 1);
        applyStimulus(32'h0000_0040, 1'b1, 1, 1);
        repeat (4) tick();
        waitDrain("bypassDrain");

        // Not-taken updates, saturating at strongly-not-taken.
        applyStimulus(32'h0000_0080, 1'b0, 1, 1);
        repeat (3) tick();
        applyStimulus(32'h0000_0080, 1'b0, 1, 1);
        repeat (3) tick();
        waitDrain("notTakenDrain");

        // Queue fills during a sweep: fifth outcome held until a pop.
        doClear(1'b1);
        repeat (10) tick();
        applyStimulus(32'h0000_0100, 1'b1, 1, 0);
        applyStimulus(32'h0000_0100, 1'b1, 1, 0);
        applyStimulus(32'h0000_0104, 1'b0, 1, 0);
        applyStimulus(32'h0000_0100, 1'b1, 1, 0);
        @(negedge clk);
        checkOutput("predLowWhileQueued", predReady, 1'b0);
        tick();
        applyStimulus(32'h0000_03FC, 1'b1, 0, 0);
        waitDrain("fullQueueDrain");
        tick();
        @(negedge clk);
        checkOutput("predReadyAfterFull", predReady, 1'b1);
        tick();

        // Clear with three outcomes queued mid-sweep: none of them written.
        doClear(1'b1);
        repeat (5) tick();
        applyStimulus(32'h0000_0200, 1'b1, 1, 0);
        applyStimulus(32'h0000_0204, 1'b1, 1, 0);
        applyStimulus(32'h0000_0208, 1'b0, 1, 0);
        repeat (3) tick();
        doClear(1'b1);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            checkOutput("predLowResweep", predReady, 1'b0);
        end
        waitDrain("clearDrain");
        tick();
        @(negedge clk);
        checkOutput("predReadyAfterClear", predReady, 1'b1);
        tick();

        // rdy low mid-sweep and mid-update.
        doClear(1'b0);
        repeat (50) tick();
        rdyLow("sweepFreeze");
        waitDrain("sweepFreezeDrain");
        applyStimulus(32'h0000_0300, 1'b1, 1, 0);
        applyStimulus(32'h0000_0300, 1'b1, 1, 0);
        applyStimulus(32'h0000_0304, 1'b0, 1, 0);
        rdyLow("updFreeze");
        waitDrain("updFreezeDrain");

        // Randomised traffic with rdy toggling; a few hot indices.
        for (int k = 0; k < 1500; k++) begin
            logic [IDX_W-1:0] ridx;
            int               sel;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       ridx = 8'h10;
                1:       ridx = 8'h11;
                2:       ridx = 8'hFF;
                default: ridx = IDX_W'($urandom());
            endcase
            rdy      = ($urandom_range(0, 7) != 0);
            robValid = $urandom_range(0, 1);
            robHit   = $urandom_range(0, 1);
            robPc    = $urandom();
            robPc[IDX_W+1:2] = ridx;
            @(negedge clk);
            if (!rdy) begin
                checkOutput("readyGated", robReady, 1'b0);
            end
            if (robValid && robReady === 1'b1) begin
                modelCommit(int'(ridx), robHit, -1);
            end
            tick();
        end
        rdy      = 1'b1;
        robValid = 1'b0;
        waitDrain("randomDrain");

        // Asynchronous reset mid-sweep.
        doClear(1'b0);
        repeat (30) tick();
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncWrEn", wrEn, 1'b0);
        checkOutput("asyncWrIdx", wrIdx, 0);
        checkOutput("asyncWrCnt", wrCnt, 2'b01);
        checkOutput("asyncPredReady", predReady, 1'b0);
        checkOutput("asyncRdIdx", rdIdx, 0);
        expWrites.delete();
        tick();
        rst = 1'b0;
        modelInitSweep(cycleCnt + 1);
        waitDrain("postResetDrain");
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
